// File: rtl/fetch_stage_if.sv
// Fetch-stage boundary bundle: the instruction-memory read handshake plus
// the IF/ID pipeline register that decode consumes.
//
//   imem_read     fetch -> mem    read request, held until imem_resp
//   imem_address  fetch -> mem    word-aligned fetch address
//   imem_rdata    mem   -> fetch  instruction, valid with imem_resp
//   imem_resp     mem   -> fetch  one-cycle completion of the read
//   if_id         fetch -> decode {intr, pc_out, brpredict}
//   if_id_valid   fetch -> decode 1 = real instruction, 0 = bubble
//
// Modports: master = fetch stage, slave = memory/decode environment.
interface fetch_stage_if;

  typedef struct packed {
    logic [15:0] intr;
    logic [15:0] pc_out;
    logic        brpredict;
  } if_id_t;

  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  if_id_t      if_id;
  logic        if_id_valid;

  modport master (
    output imem_read, imem_address, if_id, if_id_valid,
    input  imem_rdata, imem_resp
  );

  modport slave (
    input  imem_read, imem_address, if_id, if_id_valid,
    output imem_rdata, imem_resp
  );

endinterface

// File: rtl/fetch_stage.sv
// IF stage of the LC-3b pipeline. Owns the PC and the instruction-memory
// read handshake, holds the IF/ID register, and predicts BR instructions
// with a direct-mapped BHT/BTB of 2-bit saturating counters.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   bus                 fetch_stage_if.master (imem handshake + IF/ID)
//   pipe_load           decode accepts IF/ID this edge
//   redirect_valid/pc   flush from EX/MEM with the correct next PC
//   bht_update*         resolved-branch training strobe, PC, direction, target
module fetch_stage #(
  parameter int          BHT_ENTRIES = 16,
  parameter logic [15:0] RESET_PC    = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_stage_if.master        bus,
  input  logic                 pipe_load,
  input  logic                 redirect_valid,
  input  logic [15:0]          redirect_pc,
  input  logic                 bht_update,
  input  logic [15:0]          bht_update_pc,
  input  logic                 bht_update_taken,
  input  logic [15:0]          bht_update_target
);

  localparam int IDX  = $clog2(BHT_ENTRIES);
  localparam int TAGW = 15 - IDX;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] drain_addr_q;

  // IF/ID register and the one-entry skid buffer used while decode stalls.
  logic [15:0] intr_q,     buf_intr_q;
  logic [15:0] pc_out_q,   buf_pc_q;
  logic        bp_q,       buf_bp_q;
  logic        if_id_valid_q;

  // BHT/BTB storage
  logic            bht_valid_q [BHT_ENTRIES];
  logic [1:0]      bht_ctr_q   [BHT_ENTRIES];
  logic [TAGW-1:0] bht_tag_q   [BHT_ENTRIES];
  logic [15:0]     bht_tgt_q   [BHT_ENTRIES];

  // ---------------------------------------------------------------------
  // Lookup / prediction on the returning instruction
  // ---------------------------------------------------------------------
  logic [IDX-1:0]  lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            is_br;
  logic            lk_hit;
  logic            taken_pred;
  logic [15:0]     pc_plus2;
  logic [15:0]     next_pc;

  assign lk_idx     = pc_q[IDX:1];
  assign lk_tag     = pc_q[15:IDX+1];
  // BR with nzp=000 is the architectural NOP and never predicted.
  assign is_br      = (bus.imem_rdata[15:12] == 4'b0000) && (bus.imem_rdata[11:9] != 3'b000);
  assign lk_hit     = bht_valid_q[lk_idx] && (bht_tag_q[lk_idx] == lk_tag);
  assign taken_pred = is_br && lk_hit && bht_ctr_q[lk_idx][1];
  assign pc_plus2   = pc_q + 16'd2;
  assign next_pc    = taken_pred ? bht_tgt_q[lk_idx] : pc_plus2;

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.imem_read    = !reset && (state_q != ST_HOLD);
  assign bus.imem_address = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
  assign bus.if_id        = {intr_q, pc_out_q, bp_q};
  assign bus.if_id_valid  = if_id_valid_q;

  // ---------------------------------------------------------------------
  // PC / handshake FSM and IF/ID register
  // ---------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      drain_addr_q  <= RESET_PC;
      intr_q        <= 16'h0000;
      pc_out_q      <= 16'h0000;
      bp_q          <= 1'b0;
      if_id_valid_q <= 1'b0;
      buf_intr_q    <= 16'h0000;
      buf_pc_q      <= 16'h0000;
      buf_bp_q      <= 1'b0;
    end else if (redirect_valid) begin
      // Flush: bubble into decode, drop any buffered instruction.
      intr_q        <= 16'h0000;
      pc_out_q      <= 16'h0000;
      bp_q          <= 1'b0;
      if_id_valid_q <= 1'b0;
      buf_intr_q    <= 16'h0000;
      buf_pc_q      <= 16'h0000;
      buf_bp_q      <= 1'b0;
      pc_q          <= redirect_pc;
      case (state_q)
        ST_FETCH: begin
          // A read still outstanding must complete before a new address
          // may be presented; a read completing now is simply dropped.
          if (!bus.imem_resp) begin
            drain_addr_q <= pc_q;
            state_q      <= ST_DRAIN;
          end
        end
        ST_HOLD:  state_q <= ST_FETCH;
        ST_DRAIN: state_q <= ST_DRAIN;
        default:  state_q <= ST_FETCH;
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (bus.imem_resp) begin
            pc_q <= next_pc;
            if (pipe_load) begin
              intr_q        <= bus.imem_rdata;
              pc_out_q      <= pc_plus2;
              bp_q          <= taken_pred;
              if_id_valid_q <= 1'b1;
            end else begin
              buf_intr_q <= bus.imem_rdata;
              buf_pc_q   <= pc_plus2;
              buf_bp_q   <= taken_pred;
              state_q    <= ST_HOLD;
            end
          end else if (pipe_load) begin
            intr_q        <= 16'h0000;
            pc_out_q      <= 16'h0000;
            bp_q          <= 1'b0;
            if_id_valid_q <= 1'b0;
          end
        end

        ST_HOLD: begin
          if (pipe_load) begin
            intr_q        <= buf_intr_q;
            pc_out_q      <= buf_pc_q;
            bp_q          <= buf_bp_q;
            if_id_valid_q <= 1'b1;
            buf_intr_q    <= 16'h0000;
            buf_pc_q      <= 16'h0000;
            buf_bp_q      <= 1'b0;
            state_q       <= ST_FETCH;
          end
        end

        ST_DRAIN: begin
          if (pipe_load) begin
            intr_q        <= 16'h0000;
            pc_out_q      <= 16'h0000;
            bp_q          <= 1'b0;
            if_id_valid_q <= 1'b0;
          end
          // Stale data is discarded; pc already holds the redirect target.
          if (bus.imem_resp) state_q <= ST_FETCH;
        end

        default: state_q <= ST_FETCH;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // BHT training
  // ---------------------------------------------------------------------
  logic [IDX-1:0]  up_idx;
  logic [TAGW-1:0] up_tag;
  logic            up_hit;

  assign up_idx = bht_update_pc[IDX:1];
  assign up_tag = bht_update_pc[15:IDX+1];
  assign up_hit = bht_valid_q[up_idx] && (bht_tag_q[up_idx] == up_tag);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_valid_q[i] <= 1'b0;
        bht_ctr_q[i]   <= 2'b01;
      end
    end else if (bht_update) begin
      if (up_hit) begin
        if (bht_update_taken) begin
          if (bht_ctr_q[up_idx] != 2'b11) bht_ctr_q[up_idx] <= bht_ctr_q[up_idx] + 2'd1;
        end else begin
          if (bht_ctr_q[up_idx] != 2'b00) bht_ctr_q[up_idx] <= bht_ctr_q[up_idx] - 2'd1;
        end
      end else if (bht_update_taken) begin
        bht_valid_q[up_idx] <= 1'b1;
        bht_ctr_q[up_idx]   <= 2'b10;
      end
    end
  end

  // NOTE: tag and target arrays carry no reset; the valid bits gate every
  // use, so the RAM-like storage stays free of reset fan-out.
  always_ff @(posedge clk) begin
    if (!reset && bht_update && bht_update_taken) begin
      bht_tag_q[up_idx] <= up_tag;
      bht_tgt_q[up_idx] <= bht_update_target;
    end
  end

  // Bit 0 of the update PC is always zero for word-aligned instructions.
  logic unused_ok;
  assign unused_ok = bht_update_pc[0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset state, straight-line fetch, decode
// stall/HOLD, redirect with drain, BHT training and saturation, tag miss,
// PC wrap, redirect coincident with a response, and reset during DRAIN.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_load;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        bht_update;
  logic [15:0] bht_update_pc;
  logic        bht_update_taken;
  logic [15:0] bht_update_target;

  int checks = 0;
  int errors = 0;

  fetch_stage_if bus ();

  fetch_stage #(.BHT_ENTRIES(16), .RESET_PC(16'h0000)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .pipe_load         (pipe_load),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .bht_update        (bht_update),
    .bht_update_pc     (bht_update_pc),
    .bht_update_taken  (bht_update_taken),
    .bht_update_target (bht_update_target)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; pipe_load = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
    bht_update = 1'b0; bht_update_pc = 16'h0; bht_update_taken = 1'b0;
    bht_update_target = 16'h0;
    bus.imem_rdata = 16'h0; bus.imem_resp = 1'b0;

    // ---- reset state
    tick(); tick();
    check("rst_read",  {31'd0, bus.imem_read}, 32'd0);
    check("rst_if_id", {bus.if_id.intr, bus.if_id.pc_out}, 32'h0);
    check("rst_bp",    {31'd0, bus.if_id.brpredict}, 32'd0);
    check("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
    reset = 1'b0; #1;
    check("fetch0_read", {31'd0, bus.imem_read}, 32'd1);
    check("fetch0_addr", {16'd0, bus.imem_address}, 32'h0000);

    // ---- straight-line fetch, 1-cycle responses
    bus.imem_rdata = 16'h1261; bus.imem_resp = 1'b1; pipe_load = 1'b1;
    tick();
    check("i0_intr",  {16'd0, bus.if_id.intr}, 32'h1261);
    check("i0_pcout", {16'd0, bus.if_id.pc_out}, 32'h0002);
    check("i0_bp",    {31'd0, bus.if_id.brpredict}, 32'd0);
    check("i0_valid", {31'd0, bus.if_id_valid}, 32'd1);
    check("i0_next",  {16'd0, bus.imem_address}, 32'h0002);
    bus.imem_rdata = 16'h5A40;
    tick();
    check("i1_intr",  {16'd0, bus.if_id.intr}, 32'h5A40);
    check("i1_pcout", {16'd0, bus.if_id.pc_out}, 32'h0004);
    check("i1_valid", {31'd0, bus.if_id_valid}, 32'd1);
    check("i1_next",  {16'd0, bus.imem_address}, 32'h0004);

    // ---- decode stall -> HOLD
    bus.imem_rdata = 16'h3000; pipe_load = 1'b0;
    tick();
    check("hold_read", {31'd0, bus.imem_read}, 32'd0);
    check("hold_intr", {16'd0, bus.if_id.intr}, 32'h5A40);
    bus.imem_resp = 1'b0;
    tick(); tick();
    check("hold3_read",  {31'd0, bus.imem_read}, 32'd0);
    check("hold3_intr",  {16'd0, bus.if_id.intr}, 32'h5A40);
    check("hold3_valid", {31'd0, bus.if_id_valid}, 32'd1);
    pipe_load = 1'b1;
    tick();
    check("unhold_intr",  {16'd0, bus.if_id.intr}, 32'h3000);
    check("unhold_pcout", {16'd0, bus.if_id.pc_out}, 32'h0006);
    check("unhold_read",  {31'd0, bus.imem_read}, 32'd1);
    check("unhold_addr",  {16'd0, bus.imem_address}, 32'h0006);
    tick();
    check("noresp_bubble_valid", {31'd0, bus.if_id_valid}, 32'd0);
    check("noresp_bubble_intr",  {16'd0, bus.if_id.intr}, 32'h0000);
    bus.imem_rdata = 16'h1000; bus.imem_resp = 1'b1;
    tick();
    check("i3_intr", {16'd0, bus.if_id.intr}, 32'h1000);
    check("i3_next", {16'd0, bus.imem_address}, 32'h0008);
    bus.imem_resp = 1'b0;

    // ---- redirect while 0x0008 pending, response delayed
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    check("drain_addr0", {16'd0, bus.imem_address}, 32'h0008);
    check("drain_read",  {31'd0, bus.imem_read}, 32'd1);
    check("flush_valid", {31'd0, bus.if_id_valid}, 32'd0);
    tick(); tick(); tick();
    check("drain_addr3", {16'd0, bus.imem_address}, 32'h0008);
    bus.imem_rdata = 16'h1234; bus.imem_resp = 1'b1;
    tick();
    check("post_drain_addr",  {16'd0, bus.imem_address}, 32'h0100);
    check("post_drain_valid", {31'd0, bus.if_id_valid}, 32'd0);
    bus.imem_resp = 1'b0;

    // ---- train BHT at 0x0010 (install 10, then 11)
    bht_update = 1'b1; bht_update_pc = 16'h0010; bht_update_taken = 1'b1;
    bht_update_target = 16'h0040;
    tick(); tick();
    bht_update = 1'b0;
    // redirect coincident with a response: no drain
    bus.imem_rdata = 16'h5555; bus.imem_resp = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'h0010;
    tick();
    redirect_valid = 1'b0;
    check("redir_resp_addr",  {16'd0, bus.imem_address}, 32'h0010);
    check("redir_resp_read",  {31'd0, bus.imem_read}, 32'd1);
    check("redir_resp_valid", {31'd0, bus.if_id_valid}, 32'd0);
    bus.imem_rdata = 16'h0E05;
    tick();
    check("br_intr",  {16'd0, bus.if_id.intr}, 32'h0E05);
    check("br_bp",    {31'd0, bus.if_id.brpredict}, 32'd1);
    check("br_pcout", {16'd0, bus.if_id.pc_out}, 32'h0012);
    check("br_next",  {16'd0, bus.imem_address}, 32'h0040);
    redirect_valid = 1'b1; redirect_pc = 16'h0010;
    tick();
    redirect_valid = 1'b0;
    bus.imem_rdata = 16'h0000;
    tick();
    check("nop_bp",   {31'd0, bus.if_id.brpredict}, 32'd0);
    check("nop_next", {16'd0, bus.imem_address}, 32'h0012);

    // ---- 4 not-taken (11->00 saturating) then 1 taken (->01)
    bus.imem_resp = 1'b0;
    bht_update = 1'b1; bht_update_taken = 1'b0;
    tick(); tick(); tick(); tick();
    bht_update_taken = 1'b1;
    tick();
    bht_update = 1'b0;
    bus.imem_resp = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0010;
    tick();
    redirect_valid = 1'b0;
    bus.imem_rdata = 16'h0E05;
    tick();
    check("weak_nt_bp",   {31'd0, bus.if_id.brpredict}, 32'd0);
    check("weak_nt_next", {16'd0, bus.imem_address}, 32'h0012);
    // one more taken -> 10, predicts taken again
    bus.imem_resp = 1'b0;
    bht_update = 1'b1;
    tick();
    bht_update = 1'b0;
    bus.imem_resp = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0010;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("weak_t_bp",   {31'd0, bus.if_id.brpredict}, 32'd1);
    check("weak_t_next", {16'd0, bus.imem_address}, 32'h0040);

    // ---- same index, different tag (0x0030) -> no prediction
    redirect_valid = 1'b1; redirect_pc = 16'h0030;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("tagmiss_bp",    {31'd0, bus.if_id.brpredict}, 32'd0);
    check("tagmiss_pcout", {16'd0, bus.if_id.pc_out}, 32'h0032);
    check("tagmiss_next",  {16'd0, bus.imem_address}, 32'h0032);

    // ---- PC wrap at 0xFFFE
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    check("wrap_addr", {16'd0, bus.imem_address}, 32'hFFFE);
    bus.imem_rdata = 16'h1000;
    tick();
    check("wrap_pcout", {16'd0, bus.if_id.pc_out}, 32'h0000);
    check("wrap_next",  {16'd0, bus.imem_address}, 32'h0000);

    // ---- reset during DRAIN
    redirect_valid = 1'b1; redirect_pc = 16'h0080;
    tick();
    bus.imem_resp = 1'b0; redirect_pc = 16'h0200;
    tick();
    redirect_valid = 1'b0;
    check("drain2_addr", {16'd0, bus.imem_address}, 32'h0080);
    reset = 1'b1;
    tick();
    check("rst_drain_read", {31'd0, bus.imem_read}, 32'd0);
    reset = 1'b0; #1;
    check("rst_drain_addr",  {16'd0, bus.imem_address}, 32'h0000);
    check("rst_drain_rd",    {31'd0, bus.imem_read}, 32'd1);
    check("rst_drain_valid", {31'd0, bus.if_id_valid}, 32'd0);
    bus.imem_rdata = 16'h1261; bus.imem_resp = 1'b1;
    tick();
    check("after_rst_intr",  {16'd0, bus.if_id.intr}, 32'h1261);
    check("after_rst_pcout", {16'd0, bus.if_id.pc_out}, 32'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the LC-3b 5-stage pipeline; directly upstream of decode.
- Owns the PC and the instruction-memory read handshake, and holds the IF/ID pipeline register consumed by decode (intr, pc_out, brpredict).
- Contains a direct-mapped branch history/target table (2-bit counters) that predicts BR instructions at fetch time.
- Accepts redirects and BHT training from later stages.

Parameters:
BHT_ENTRIES, 16, number of BHT/BTB entries (power of two, 2..64); IDX = log2(BHT_ENTRIES)
RESET_PC, 16'h0000, PC loaded on reset

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
imem_read  out  1  instruction read request; held until imem_resp
imem_address  out  16  word-aligned fetch address; stable while imem_read=1
imem_rdata  in  16  instruction returned; valid when imem_resp=1
imem_resp  in  1  one-cycle completion of the current read
pipe_load  in  1  decode accepts IF/ID contents this edge (same signal decode uses to load ID/EX)
redirect_valid  in  1  mispredict/jump/trap flush from EX/MEM
redirect_pc  in  16  correct next PC
bht_update  in  1  resolved BR training strobe
bht_update_pc  in  16  PC of the resolved BR (not incremented)
bht_update_taken  in  1  resolved direction
bht_update_target  in  16  resolved taken target
if_id  out  IF_ID  {intr, pc_out, brpredict} to decode
if_id_valid  out  1  1 = real instruction, 0 = bubble

Behaviour:
- Reset: pc=RESET_PC; state=FETCH; buffer empty; if_id={16'h0000,16'h0000,0}; if_id_valid=0; all BHT valid bits=0, counters=2'b01.
- Reset mid-request: the response is ignored; fetch restarts at RESET_PC.
- Bubble: intr=16'h0000 (BR nzp=000, architectural NOP), pc_out=0, brpredict=0, valid=0.
- imem_read=1 in FETCH and DRAIN, 0 in HOLD and during reset.
- imem_address=pc in FETCH; drain_addr in DRAIN.

States:
- FETCH: read pc.
  - On imem_resp with pipe_load=1: IF/ID<={rdata, pc+2, pred}, valid=1; pc<=next_pc; stay in FETCH.
  - On imem_resp with pipe_load=0: buffer<=same tuple; pc<=next_pc; go to HOLD.
  - No resp and pipe_load=1: IF/ID<=bubble.
  - No resp and pipe_load=0: IF/ID holds.
- HOLD: no request.
  - On pipe_load: IF/ID<=buffer; clear buffer; go to FETCH.
- DRAIN: keep the stale request alive until imem_resp.
  - Discard the response; go to FETCH at pc (already redirected).
  - IF/ID<=bubble on pipe_load.

Prediction (combinational on imem_rdata; fetch PC p):
- index = p[IDX:1]; tag = p[15:IDX+1].
- taken_pred = (rdata[15:12]==4'b0000) & (rdata[11:9]!=0) & valid[index] & tag match & counter[1].
- next_pc = taken_pred ? target[index] : p+2 (16-bit wrap, 16'hFFFE+2=0).
- pc_out = p+2 always.

Redirect (priority over everything except reset):
- IF/ID<=bubble and buffer cleared regardless of pipe_load; pc<=redirect_pc.
- FETCH without resp that cycle: drain_addr<=pc; go to DRAIN.
- FETCH with resp that cycle: discard the data; stay in FETCH (no drain).
- HOLD: go to FETCH.
- DRAIN: stay in DRAIN; pc<=latest redirect_pc.

BHT update (index/tag from bht_update_pc):
- Entry hit (valid & tag match):
  - taken: counter saturating +1 (max 11); target<=bht_update_target.
  - not taken: counter saturating -1 (min 00).
- Miss & taken: install tag, target, valid=1, counter=2'b10.
- Miss & not taken: no change.
- Update and lookup to the same index in one cycle: lookup sees pre-update contents.

Test Plan:
- Reset then 1-cycle-resp memory returning 0x1261 at 0x0000 and 0x5A40 at 0x0002, pipe_load=1 -> imem_address sequence 0x0000, 0x0002, 0x0004; if_id = {0x1261, pc_out 0x0002, bp 0}, then {0x5A40, 0x0004}; valid=1.
- pipe_load=0 for 3 cycles after a response -> HOLD, imem_read=0, if_id unchanged; pipe_load=1 -> buffered instruction appears in if_id next edge, fetch resumes at next PC.
- redirect_valid (redirect_pc=0x0100) while the read of 0x0008 is pending with resp delayed 4 cycles -> imem_address stays 0x0008 until resp; data discarded; next read is 0x0100; if_id bubble (0x0000, valid 0) after the flush edge.
- Two bht_update at pc 0x0010, taken, target 0x0040; then fetch 0x0010 returning 0x0E05 (BRnzp) -> brpredict=1, next imem_address=0x0040; instruction 0x0000 at the same PC -> not predicted, next 0x0012.
- Four not-taken updates then one taken on the trained entry -> counter sequence 11 -> 00 (saturates), then 01; fetch at 0x0010 predicts not taken.
- Redirect coincident with imem_resp in FETCH -> response discarded, no DRAIN entered, next read at redirect_pc on the following cycle; reset asserted mid-DRAIN -> next read at RESET_PC.
